// File: rtl/fdiv_pkg.sv
// Shared types and defaults for the glitch-free clock-enable divider controller.
package fdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } fdiv_state_t;

  localparam int FDIV_W_DEF    = 16;
  localparam int FDIV_DEF_HALF = 3;

endpackage

// File: rtl/fdiv_core.sv
// Count/toggle datapath of the divider: counts to half-1, flips out, flags the 1->0 boundary.
module fdiv_core
  import fdiv_pkg::*;
#(
  parameter int W = FDIV_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         load,
  input  logic [W-1:0] half,
  output logic         out,
  output logic         tick,
  output logic         boundary
);

  logic [W-1:0] count;
  logic         wrap;

  assign wrap = (count == half - W'(1));

  // Not gated by run so the controller can use it without a combinational loop;
  // count and out are held at zero whenever the divider is not running.
  assign boundary = wrap & out;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
      out   <= 1'b0;
      tick  <= 1'b0;
    end else if (run) begin
      if (wrap) begin
        count <= '0;
        out   <= ~out;
      end else begin
        count <= count + W'(1);
      end
      tick <= wrap & ~out;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// Runtime-programmable glitch-free divider controller: config handshake, pending slot and FSM.
// Optional feature macro: FDIV_PERIOD_CNT_EN adds the period_cnt output and counter.
module freq_div_ctrl
  import fdiv_pkg::*;
#(
  parameter int W        = FDIV_W_DEF,
  parameter int DEF_HALF = FDIV_DEF_HALF
`ifdef FDIV_PERIOD_CNT_EN
  ,
  parameter int PCNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [W-1:0]      cfg_half,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              busy,
  output logic              out,
  output logic              tick
`ifdef FDIV_PERIOD_CNT_EN
  ,
  output logic [PCNT_W-1:0] period_cnt
`endif
);

  fdiv_state_t  state, next_state;
  logic [W-1:0] active_half;
  logic [W-1:0] pend_half;
  logic         pend_flag;
  logic         core_run;
  logic         core_load;
  logic         boundary;
  logic         accept;
  logic         cfg_zero;
  logic         cfg_good;
  logic         apply_pend;

  assign cfg_ready = ~pend_flag;
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign cfg_zero  = (cfg_half == '0);
  assign cfg_good  = accept & ~cfg_zero;

  fdiv_core #(
    .W(W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .run      (core_run),
    .load     (core_load),
    .half     (active_half),
    .out      (out),
    .tick     (tick),
    .boundary (boundary)
  );

  always_comb begin
    next_state = state;
    core_run   = 1'b0;
    core_load  = 1'b0;
    case (state)
      IDLE: begin
        core_load = 1'b1;
        if (en) next_state = RUN;
      end
      RUN: begin
        core_run = 1'b1;
        if (!en) begin
          // Low phase can be cut safely; a high phase must be allowed to finish.
          if (!out) begin
            next_state = IDLE;
            core_load  = 1'b1;
          end else if (boundary) begin
            next_state = IDLE;
          end else begin
            next_state = STOP;
          end
        end
      end
      STOP: begin
        core_run = 1'b1;
        if (en) next_state = RUN;
        else if (boundary) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pending ratio lands at a boundary, or on any return to IDLE so the slot never stays full.
  assign apply_pend = pend_flag & (state != IDLE) & (boundary | (next_state == IDLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_half <= W'(DEF_HALF);
      pend_flag   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state   <= next_state;
      cfg_err <= accept & cfg_zero;
      if (state == IDLE) begin
        if (cfg_good) active_half <= cfg_half;
      end else begin
        if (apply_pend) begin
          active_half <= pend_half;
          pend_flag   <= 1'b0;
        end
        if (cfg_good) pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_good && state != IDLE) pend_half <= cfg_half;
  end

`ifdef FDIV_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (state != IDLE && boundary) begin
      period_cnt <= period_cnt + PCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: vector table of ratios plus hand-written corner sequences.
module tb_freq_div_ctrl;
  import fdiv_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_half = '0;
  logic         cfg_ready, cfg_err, busy, out, tick;
`ifdef FDIV_PERIOD_CNT_EN
  logic [3:0]   period_cnt;
`endif

  freq_div_ctrl #(
    .W        (W),
    .DEF_HALF (3)
`ifdef FDIV_PERIOD_CNT_EN
    ,
    .PCNT_W   (4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_half   (cfg_half),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .out        (out),
    .tick       (tick)
`ifdef FDIV_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    exp;
  } sb_t;

  typedef struct {
    int half;     // 0: keep reset default
    int first;    // cycles from busy rising to out rising
    int high;     // high-phase width
    int period;   // tick spacing
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check(input int act);
    sb_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d with nothing expected", act);
    end else begin
      e = sb.pop_front();
      if (e.exp != act) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic offer_cfg(input int h);
    cfg_valid = 1'b1;
    cfg_half  = W'(h);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_out(input logic v);
    int n = 0;
    while (out !== v && n < 100) begin
      step();
      n++;
    end
    if (out !== v) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_out: out stuck at %b, wanted %b", out, v);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 100);
    if (!tick) n = -1;
  endtask

  // Raise en and measure first-rise latency, high width and tick spacing.
  task automatic measure(output int first, output int high, output int per);
    int t_busy, t_rise, t_fall, t_tick2;
    first = -1; high = -1; per = -1;
    t_busy = -1; t_rise = -1; t_fall = -1; t_tick2 = -1;
    en = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (t_busy < 0 && busy) t_busy = n;
      if (t_rise < 0 && out) t_rise = n;
      else if (t_rise >= 0 && t_fall < 0 && !out) t_fall = n;
      if (tick && t_rise >= 0 && n > t_rise) begin
        t_tick2 = n;
        break;
      end
    end
    if (t_rise >= 0 && t_busy >= 0) first = t_rise - t_busy;
    if (t_fall >= 0) high = t_fall - t_rise;
    if (t_tick2 >= 0) per = t_tick2 - t_rise;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, h, p, n, hi, bad, prev, falls;

    vecs[0] = '{half: 0, first: 3, high: 3, period: 6};
    vecs[1] = '{half: 5, first: 5, high: 5, period: 10};
    vecs[2] = '{half: 1, first: 1, high: 1, period: 2};
    vecs[3] = '{half: 2, first: 2, high: 2, period: 4};
    vecs[4] = '{half: 7, first: 7, high: 7, period: 14};

    // Reset state
    do_reset();
    expect_val("rst_out", 0);       check(int'(out));
    expect_val("rst_tick", 0);      check(int'(tick));
    expect_val("rst_busy", 0);      check(int'(busy));
    expect_val("rst_cfg_ready", 1); check(int'(cfg_ready));
    expect_val("rst_cfg_err", 0);   check(int'(cfg_err));
`ifdef FDIV_PERIOD_CNT_EN
    expect_val("rst_period_cnt", 0); check(int'(period_cnt));
`endif

    // Ratio table, each configured in IDLE
    for (int i = 0; i < 5; i++) begin
      do_reset();
      if (vecs[i].half != 0) offer_cfg(vecs[i].half);
      expect_val($sformatf("v%0d_first_rise", i), vecs[i].first);
      expect_val($sformatf("v%0d_high", i), vecs[i].high);
      expect_val($sformatf("v%0d_tick_spacing", i), vecs[i].period);
      measure(f, h, p);
      check(f);
      check(h);
      check(p);
      expect_val($sformatf("v%0d_busy_running", i), 1);
      check(int'(busy));
    end

    // Zero half-period is rejected with a one-cycle error pulse
    do_reset();
    expect_val("zero_cfg_err_pulse", 1);
    expect_val("zero_cfg_ready", 1);
    offer_cfg(0);
    check(int'(cfg_err));
    check(int'(cfg_ready));
    expect_val("zero_cfg_err_clear", 0);
    step();
    check(int'(cfg_err));
    expect_val("zero_first_rise", 3);
    expect_val("zero_high", 3);
    expect_val("zero_tick_spacing", 6);
    measure(f, h, p);
    check(f);
    check(h);
    check(p);

    // Ratio change requested in the middle of a high phase
    do_reset();
    en = 1'b1;
    wait_out(1'b1);
    expect_val("chg_ready_pending", 0);
    offer_cfg(1);
    check(int'(cfg_ready));
    hi = 2;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!out) break;
      hi++;
      if (cfg_ready) bad = 1;
    end
    expect_val("chg_high_not_cut", 3);     check(hi);
    expect_val("chg_ready_early", 0);      check(bad);
    expect_val("chg_ready_at_boundary", 1); check(int'(cfg_ready));
    expect_val("chg_low_after_boundary", 1);
    wait_tick(n);
    check(n);
    expect_val("chg_tick_spacing_a", 2);
    wait_tick(n);
    check(n);
    expect_val("chg_tick_spacing_b", 2);
    wait_tick(n);
    check(n);

    // en dropped while out is high: high phase completes, then IDLE
    do_reset();
    en = 1'b1;
    wait_out(1'b1);
    en = 1'b0;
    expect_val("stop_busy", 1);
    step();
    check(int'(busy));
    hi = 2;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!out) break;
      hi++;
    end
    expect_val("stop_high_complete", 3); check(hi);
    expect_val("stop_idle_at_boundary", 0); check(int'(busy));
    step();
    step();
    expect_val("stop_out_stays_low", 0); check(int'(out));

    // en dropped while out is low: IDLE on the next cycle
    do_reset();
    en = 1'b1;
    wait_out(1'b1);
    wait_out(1'b0);
    en = 1'b0;
    step();
    expect_val("drop_low_busy", 0); check(int'(busy));
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out || tick) bad = 1;
    end
    expect_val("drop_low_quiet", 0); check(bad);

    // Reset while running with a config pending
    do_reset();
    en = 1'b1;
    wait_out(1'b1);
    offer_cfg(7);
    expect_val("mid_pending", 0); check(int'(cfg_ready));
    rst = 1'b1;
    step();
    expect_val("mid_rst_out", 0);       check(int'(out));
    expect_val("mid_rst_tick", 0);      check(int'(tick));
    expect_val("mid_rst_busy", 0);      check(int'(busy));
    expect_val("mid_rst_cfg_err", 0);   check(int'(cfg_err));
    expect_val("mid_rst_cfg_ready", 1); check(int'(cfg_ready));
    rst = 1'b0;
    en  = 1'b0;
    expect_val("mid_rst_first_rise", 3);
    expect_val("mid_rst_high", 3);
    expect_val("mid_rst_tick_spacing", 6);
    measure(f, h, p);
    check(f);
    check(h);
    check(p);

`ifdef FDIV_PERIOD_CNT_EN
    // Period counter wraps at 16 periods
    do_reset();
    offer_cfg(1);
    en = 1'b1;
    falls = 0;
    prev = 0;
    for (int k = 0; k < 200 && falls < 17; k++) begin
      step();
      if (prev == 1 && !out) falls++;
      prev = int'(out);
    end
    expect_val("pcnt_wrap", 1); check(int'(period_cnt));
    rst = 1'b1;
    step();
    expect_val("pcnt_rst", 0);     check(int'(period_cnt));
    expect_val("pcnt_rst_out", 0); check(int'(out));
    rst = 1'b0;
    en  = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
